pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 stall_i  input  1  decode stage not ready; hold PC and IF/ID contents.
REQ-005 branch_flag_i  input  1  taken branch/jump resolved in decode.
REQ-006 branch_target_i  input  32  branch destination byte address.
REQ-007 flush_i  input  1  exception/ERET redirect; kills the fetched instruction.
REQ-008 new_pc_i  input  32  redirect address accompanying flush_i.
REQ-009 inst_i  input  32  instruction word from ROM, combinational on ce_o/pc_o in the same cycle.
REQ-010 ce_o  output  1  ROM chip enable.
REQ-011 pc_o  output  32  ROM byte address; the ROM indexes by pc_o[11:2].
REQ-012 id_pc_o  output  32  PC of the instruction presented to decode.
REQ-013 id_inst_o  output  32  instruction presented to decode.
REQ-014 id_valid_o  output  1  id_inst_o is a real instruction, not a bubble.
REQ-015 id_adel_o  output  1  fetch address error on the presented instruction.

Function
REQ-016 FSM states: S_RST (ce_o=0) and S_RUN (ce_o=1); S_RST->S_RUN on the first clock with rst_n=1; S_RUN->S_RST only on reset.
REQ-017 S_RST: pc_o holds RESET_PC; IF/ID holds a bubble (id_pc_o=0, id_inst_o=0, id_valid_o=0, id_adel_o=0).
REQ-018 S_RUN update priority per edge: flush_i > stall_i > branch_flag_i > sequential.
REQ-019 flush_i=1: pc_o<=new_pc_i; IF/ID<=bubble; stall_i ignored that cycle.
REQ-020 stall_i=1 (no flush): pc_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o hold; branch_flag_i not sampled.
REQ-021 branch_flag_i=1 (no flush, no stall): pc_o<=branch_target_i; IF/ID captures the current fetch normally. That instruction is the MIPS delay slot and is never squashed.
REQ-022 Sequential: pc_o<=pc_o+4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000); IF/ID<={pc_o, inst_i}, valid=1.
REQ-023 Misaligned fetch (pc_o[1:0]!=2'b00 in S_RUN): ce_o=0 that cycle; captured entry is id_inst_o=0, id_valid_o=1, id_adel_o=1, id_pc_o=pc_o. The PC advances per REQ-018.
REQ-024 Fetch latency: the instruction at address A appears on id_inst_o exactly one cycle after pc_o=A, absent stall or flush.
REQ-025 In S_RUN, ce_o is combinational on state and pc_o[1:0] only, with no path from stall_i, branch or flush inputs.
REQ-026 IF/ID never captures inst_i while ce_o=0.

Reset
REQ-027 rst_n=0 sampled on any edge, including mid-stall or mid-branch, forces S_RST, pc_o=RESET_PC and a bubble on IF/ID on that edge; all other inputs are ignored.
REQ-028 First cycle after rst_n rises: ce_o=1 and pc_o=RESET_PC.

Structure
REQ-029 Shared package/defines file holds ZERO_WORD, NOP_INST (32'h0), INST_ADDR_W (32), INST_W (32), PC_STEP (4) and the FSM state encodings.
REQ-030 The IF/ID pipeline register is a sub-module named if_id (stall/flush/bubble logic). pc_fetch instantiates it; PC register and FSM stay in pc_fetch.
REQ-031 No memories and no multi-cycle arithmetic; a single 32-bit incrementer.

Verification
REQ-032 Reset, then 4 free-run cycles with a ROM model of words 0..3 = 34080001, 34090001, 01095021, 35280000 -> pc_o 0,4,8,C; id_inst_o lags by one cycle; id_valid_o=1 from the second S_RUN cycle.
REQ-033 Branch asserted with pc_o=0x18, target 0x0C -> delay-slot word at 0x18 reaches decode with valid=1; next pc_o=0x0C.
REQ-034 stall_i held 3 cycles while branch_flag_i=1 at pc_o=0x10 -> pc_o and IF/ID frozen for 3 cycles; branch taken on the first unstalled edge.
REQ-035 flush_i with stall_i in the same cycle, new_pc_i=0x180 -> pc_o=0x180 next cycle; id_valid_o=0.
REQ-036 branch_target_i=0x0000_0006 -> ce_o=0 at pc_o=0x06; next id_adel_o=1, id_inst_o=0, id_pc_o=0x06.
REQ-037 rst_n pulled low during a stall, and separately pc_o=0xFFFF_FFFC free-running -> pc_o=RESET_PC and bubble next cycle after reset; wrap to 0x0 after 0xFFFF_FFFC.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// ============================================================================
// pc_fetch_pkg : shared widths, constants and FSM encoding for the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [INST_W-1:0]      NOP_INST  = 32'h0000_0000;
    localparam logic [INST_ADDR_W-1:0] PC_STEP   = 32'h0000_0004;

    typedef enum logic [0:0] {
        S_RST = 1'b0,
        S_RUN = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_if_id.sv
// ============================================================================
// if_id : IF/ID pipeline register with stall hold, flush bubble and reset bubble
// Rev 1.0
// ============================================================================
`default_nettype none

module if_id
    import pc_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   ce_i,
    input  logic                   adel_i,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0]      inst_i,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0]      id_inst_o,
    output logic                   id_valid_o,
    output logic                   id_adel_o
);

    logic [INST_ADDR_W-1:0] id_pc_q,    id_pc_d;
    logic [INST_W-1:0]      id_inst_q,  id_inst_d;
    logic                   id_valid_q, id_valid_d;
    logic                   id_adel_q,  id_adel_d;

    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        id_adel_d  = id_adel_q;
        if (!run_i || flush_i) begin
            id_pc_d    = ZERO_WORD;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            id_adel_d  = 1'b0;
        end else if (!stall_i) begin
            // With the ROM disabled the bus is meaningless, so never latch it
            id_pc_d    = pc_i;
            id_inst_d  = ce_i ? inst_i : NOP_INST;
            id_valid_d = 1'b1;
            id_adel_d  = adel_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_pc_q    <= ZERO_WORD;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            id_adel_q  <= 1'b0;
        end else begin
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            id_adel_q  <= id_adel_d;
        end
    end

    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    assign id_valid_o = id_valid_q;
    assign id_adel_o  = id_adel_q;

endmodule

`default_nettype wire

// File: rtl/pc_fetch.sv
// ============================================================================
// pc_fetch : PC register, reset/run FSM and ROM interface of the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    input  logic                   flush_i,
    input  logic [INST_ADDR_W-1:0] new_pc_i,
    input  logic [INST_W-1:0]      inst_i,
    output logic                   ce_o,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0]      id_inst_o,
    output logic                   id_valid_o,
    output logic                   id_adel_o
);

    state_t                 state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q,    pc_d;
    logic                   run;
    logic                   adel;

    assign run  = (state_q == S_RUN);
    // ce depends only on state and alignment so control inputs never gate the ROM
    assign adel = run && (pc_q[1:0] != 2'b00);
    assign ce_o = run && (pc_q[1:0] == 2'b00);
    assign pc_o = pc_q;

    always_comb begin
        state_d = S_RUN;
        pc_d    = pc_q;
        if (!run) begin
            pc_d = RESET_PC;
        end else if (flush_i) begin
            pc_d = new_pc_i;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (branch_flag_i) begin
            pc_d = branch_target_i;
        end else begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RST;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .ce_i       (ce_o),
        .adel_i     (adel),
        .pc_i       (pc_q),
        .inst_i     (inst_i),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o),
        .id_adel_o  (id_adel_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// ============================================================================
// tb_pc_fetch : directed-vector bench for pc_fetch with a small ROM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic [31:0] inst_i;
    logic        ce_o;
    logic [31:0] pc_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        id_adel_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .inst_i          (inst_i),
        .ce_o            (ce_o),
        .pc_o            (pc_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o),
        .id_adel_o       (id_adel_o)
    );

    // ROM: first four words are the program; others are a tag of the address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a[11:2])
            10'd0:   rom = 32'h3408_0001;
            10'd1:   rom = 32'h3409_0001;
            10'd2:   rom = 32'h0109_5021;
            10'd3:   rom = 32'h3528_0000;
            default: rom = {20'hA5A5A, a[11:0]};
        endcase
    endfunction

    // Garbage on the bus while disabled exposes any capture with ce_o low.
    always_comb inst_i = ce_o ? rom(pc_o) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        // comparison bookkeeping is inline in each scenario; this only formats
        $display("FAIL %s: got %h want %h", name, got, exp);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
        flush_i = 1'b0; new_pc_i = 32'h0;
        tick(); tick();
        n_vec++; if (ce_o !== 1'b0)      begin n_err++; chk("rst_ce", {31'b0, ce_o}, 32'h0); end
        n_vec++; if (pc_o !== 32'h0)     begin n_err++; chk("rst_pc", pc_o, 32'h0); end
        n_vec++; if (id_valid_o !== 1'b0) begin n_err++; chk("rst_valid", {31'b0, id_valid_o}, 32'h0); end
        n_vec++; if (id_inst_o !== 32'h0) begin n_err++; chk("rst_inst", id_inst_o, 32'h0); end
        n_vec++; if (id_pc_o !== 32'h0)   begin n_err++; chk("rst_idpc", id_pc_o, 32'h0); end
        n_vec++; if (id_adel_o !== 1'b0)  begin n_err++; chk("rst_adel", {31'b0, id_adel_o}, 32'h0); end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc   [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        logic [31:0] exp_inst [5] = '{32'h0, 32'h3408_0001, 32'h3409_0001, 32'h0109_5021, 32'h3528_0000};
        logic [31:0] exp_idpc [5] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
        logic        exp_val  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (pc_o !== exp_pc[i])        begin n_err++; chk($sformatf("run_pc%0d", i), pc_o, exp_pc[i]); end
            n_vec++; if (ce_o !== 1'b1)             begin n_err++; chk($sformatf("run_ce%0d", i), {31'b0, ce_o}, 32'h1); end
            n_vec++; if (id_inst_o !== exp_inst[i]) begin n_err++; chk($sformatf("run_inst%0d", i), id_inst_o, exp_inst[i]); end
            n_vec++; if (id_pc_o !== exp_idpc[i])   begin n_err++; chk($sformatf("run_idpc%0d", i), id_pc_o, exp_idpc[i]); end
            n_vec++; if (id_valid_o !== exp_val[i]) begin n_err++; chk($sformatf("run_val%0d", i), {31'b0, id_valid_o}, {31'b0, exp_val[i]}); end
        end
    endtask

    task automatic test_stall_branch();
        stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (pc_o !== 32'h10)           begin n_err++; chk($sformatf("stall_pc%0d", i), pc_o, 32'h10); end
            n_vec++; if (id_inst_o !== 32'h3528_0000) begin n_err++; chk($sformatf("stall_inst%0d", i), id_inst_o, 32'h3528_0000); end
            n_vec++; if (id_pc_o !== 32'hC)         begin n_err++; chk($sformatf("stall_idpc%0d", i), id_pc_o, 32'hC); end
            n_vec++; if (id_valid_o !== 1'b1)       begin n_err++; chk($sformatf("stall_val%0d", i), {31'b0, id_valid_o}, 32'h1); end
        end
        stall_i = 1'b0;
        tick();
        branch_flag_i = 1'b0;
        n_vec++; if (pc_o !== 32'h40)        begin n_err++; chk("unstall_pc", pc_o, 32'h40); end
        n_vec++; if (id_pc_o !== 32'h10)     begin n_err++; chk("unstall_idpc", id_pc_o, 32'h10); end
        n_vec++; if (id_inst_o !== 32'hA5A5_A010) begin n_err++; chk("unstall_inst", id_inst_o, 32'hA5A5_A010); end
    endtask

    task automatic test_branch_delay_slot();
        branch_flag_i = 1'b1; branch_target_i = 32'h18;
        tick();
        n_vec++; if (pc_o !== 32'h18) begin n_err++; chk("br1_pc", pc_o, 32'h18); end
        branch_target_i = 32'h0C;
        tick();
        branch_flag_i = 1'b0;
        n_vec++; if (pc_o !== 32'h0C)            begin n_err++; chk("br2_pc", pc_o, 32'h0C); end
        n_vec++; if (id_pc_o !== 32'h18)         begin n_err++; chk("slot_idpc", id_pc_o, 32'h18); end
        n_vec++; if (id_inst_o !== 32'hA5A5_A018) begin n_err++; chk("slot_inst", id_inst_o, 32'hA5A5_A018); end
        n_vec++; if (id_valid_o !== 1'b1)        begin n_err++; chk("slot_val", {31'b0, id_valid_o}, 32'h1); end
        tick();
        n_vec++; if (pc_o !== 32'h10)            begin n_err++; chk("tgt_pc", pc_o, 32'h10); end
        n_vec++; if (id_inst_o !== 32'h3528_0000) begin n_err++; chk("tgt_inst", id_inst_o, 32'h3528_0000); end
    endtask

    task automatic test_flush();
        stall_i = 1'b1; flush_i = 1'b1; new_pc_i = 32'h180;
        tick();
        stall_i = 1'b0; flush_i = 1'b0;
        n_vec++; if (pc_o !== 32'h180)    begin n_err++; chk("fl_pc", pc_o, 32'h180); end
        n_vec++; if (id_valid_o !== 1'b0) begin n_err++; chk("fl_val", {31'b0, id_valid_o}, 32'h0); end
        n_vec++; if (id_inst_o !== 32'h0) begin n_err++; chk("fl_inst", id_inst_o, 32'h0); end
        tick();
        n_vec++; if (pc_o !== 32'h184)            begin n_err++; chk("fl_next_pc", pc_o, 32'h184); end
        n_vec++; if (id_pc_o !== 32'h180)         begin n_err++; chk("fl_next_idpc", id_pc_o, 32'h180); end
        n_vec++; if (id_inst_o !== 32'hA5A5_A180) begin n_err++; chk("fl_next_inst", id_inst_o, 32'hA5A5_A180); end
    endtask

    task automatic test_misaligned();
        branch_flag_i = 1'b1; branch_target_i = 32'h6;
        tick();
        branch_flag_i = 1'b0;
        n_vec++; if (pc_o !== 32'h6)  begin n_err++; chk("mis_pc", pc_o, 32'h6); end
        n_vec++; if (ce_o !== 1'b0)   begin n_err++; chk("mis_ce", {31'b0, ce_o}, 32'h0); end
        tick();
        n_vec++; if (pc_o !== 32'hA)      begin n_err++; chk("mis_next_pc", pc_o, 32'hA); end
        n_vec++; if (id_adel_o !== 1'b1)  begin n_err++; chk("mis_adel", {31'b0, id_adel_o}, 32'h1); end
        n_vec++; if (id_inst_o !== 32'h0) begin n_err++; chk("mis_inst", id_inst_o, 32'h0); end
        n_vec++; if (id_pc_o !== 32'h6)   begin n_err++; chk("mis_idpc", id_pc_o, 32'h6); end
        n_vec++; if (id_valid_o !== 1'b1) begin n_err++; chk("mis_val", {31'b0, id_valid_o}, 32'h1); end
        flush_i = 1'b1; new_pc_i = 32'h20;
        tick();
        flush_i = 1'b0;
        n_vec++; if (ce_o !== 1'b1)       begin n_err++; chk("realign_ce", {31'b0, ce_o}, 32'h1); end
        n_vec++; if (id_adel_o !== 1'b0)  begin n_err++; chk("realign_adel", {31'b0, id_adel_o}, 32'h0); end
    endtask

    task automatic test_reset_mid_stall();
        stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h99;
        tick();
        n_vec++; if (pc_o !== 32'h20) begin n_err++; chk("pre_rst_pc", pc_o, 32'h20); end
        rst_n = 1'b0;
        tick();
        n_vec++; if (pc_o !== 32'h0)      begin n_err++; chk("mid_rst_pc", pc_o, 32'h0); end
        n_vec++; if (ce_o !== 1'b0)       begin n_err++; chk("mid_rst_ce", {31'b0, ce_o}, 32'h0); end
        n_vec++; if (id_valid_o !== 1'b0) begin n_err++; chk("mid_rst_val", {31'b0, id_valid_o}, 32'h0); end
        n_vec++; if (id_pc_o !== 32'h0)   begin n_err++; chk("mid_rst_idpc", id_pc_o, 32'h0); end
        rst_n = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0;
        tick();
        n_vec++; if (pc_o !== 32'h0)      begin n_err++; chk("rel_pc", pc_o, 32'h0); end
        n_vec++; if (ce_o !== 1'b1)       begin n_err++; chk("rel_ce", {31'b0, ce_o}, 32'h1); end
        n_vec++; if (id_valid_o !== 1'b0) begin n_err++; chk("rel_val", {31'b0, id_valid_o}, 32'h0); end
        tick();
        n_vec++; if (id_inst_o !== 32'h3408_0001) begin n_err++; chk("rel_inst", id_inst_o, 32'h3408_0001); end
        n_vec++; if (pc_o !== 32'h4)              begin n_err++; chk("rel_pc2", pc_o, 32'h4); end
    endtask

    task automatic test_wrap();
        flush_i = 1'b1; new_pc_i = 32'hFFFF_FFF8;
        tick();
        flush_i = 1'b0;
        tick();
        n_vec++; if (pc_o !== 32'hFFFF_FFFC)    begin n_err++; chk("wrap_pc0", pc_o, 32'hFFFF_FFFC); end
        n_vec++; if (id_pc_o !== 32'hFFFF_FFF8) begin n_err++; chk("wrap_idpc0", id_pc_o, 32'hFFFF_FFF8); end
        tick();
        n_vec++; if (pc_o !== 32'h0)              begin n_err++; chk("wrap_pc1", pc_o, 32'h0); end
        n_vec++; if (id_pc_o !== 32'hFFFF_FFFC)   begin n_err++; chk("wrap_idpc1", id_pc_o, 32'hFFFF_FFFC); end
        n_vec++; if (id_inst_o !== 32'hA5A5_AFFC) begin n_err++; chk("wrap_inst1", id_inst_o, 32'hA5A5_AFFC); end
        tick();
        n_vec++; if (pc_o !== 32'h4)              begin n_err++; chk("wrap_pc2", pc_o, 32'h4); end
        n_vec++; if (id_inst_o !== 32'h3408_0001) begin n_err++; chk("wrap_inst2", id_inst_o, 32'h3408_0001); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall_branch();
        test_branch_delay_slot();
        test_flush();
        test_misaligned();
        test_reset_mid_stall();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
